level_blink_ctrl: RTL and testbench
===================================

LEVEL_BLINK_CTRL -- requirements
Module: level_blink_ctrl

Interface
REQ-001 Parameter BLINK_DIV, default 25000000, blink half-period in clk cycles; legal range ≥2.
REQ-002 Parameter COMMIT_TOGGLES, default 6, number of prescaler terminal events from pending entry to commit; legal range ≥1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 inc_in  input  1  raw increment request, active-high, asynchronous to clk.
REQ-006 dec_in  input  1  raw decrement request, active-high, asynchronous to clk.
REQ-007 count  output  3  committed level 0..7, registered; drives the row decoder count input.
REQ-008 blink  output  1  registered preview flag; when 1, the row decoder shows count+1 bars.
REQ-009 busy  output  1  high while an increment is pending; decoded from the registered state.

Function
REQ-010 Each raw input SHALL pass a two-flop synchroniser, then rising-edge detection, yielding one-cycle pulses inc_p and dec_p.
REQ-011 An input first sampled high at edge N SHALL produce a pulse that acts at edge N+2.
REQ-012 The FSM SHALL have two states: IDLE (busy=0) and PEND (busy=1).
REQ-013 IDLE, dec_p, count>0: count decrements by 1, and the FSM stays in IDLE.
REQ-014 IDLE, dec_p, count=0: no change; no wrap to 7.
REQ-015 IDLE, inc_p, no dec_p, count<7: FSM goes to PEND, blink goes to 1, and the prescaler and toggle counter clear to 0, all on the same edge.
REQ-016 IDLE, inc_p, count=7: ignored; blink stays 0.
REQ-017 IDLE, inc_p and dec_p on the same cycle: dec_p wins, inc_p is discarded.
REQ-018 PEND prescaler: counts 0..BLINK_DIV-1; the terminal event occurs when it is at BLINK_DIV-1, and it then wraps to 0.
REQ-019 PEND terminal events 1..COMMIT_TOGGLES-1 SHALL toggle blink and increment the toggle counter.
REQ-020 On terminal event COMMIT_TOGGLES, all on that edge: count increments by 1, blink goes to 0, the FSM goes to IDLE, and the counters clear.
REQ-021 PEND, dec_p, including on a terminal-event cycle: cancel; count unchanged, blink goes to 0, FSM goes to IDLE, counters clear.
REQ-022 PEND, inc_p: ignored.
REQ-023 In IDLE, blink SHALL be 0 and the prescaler SHALL be held at 0.
REQ-024 count SHALL never leave 0..7; all arithmetic is unsigned.
REQ-025 Prescaler width SHALL be $clog2(BLINK_DIV); toggle-counter width SHALL be $clog2(COMMIT_TOGGLES+1).

Reset
REQ-026 rst_n low SHALL immediately force: count=0, blink=0, busy=0, state=IDLE, prescaler=0, toggle counter=0, synchroniser and edge flops=0.
REQ-027 Reset asserted mid-PEND SHALL discard the pending increment.
REQ-028 Reset release SHALL take effect on the first clk edge after rst_n rises.
REQ-029 An input held high across reset release SHALL produce one pulse after release.

Structure
REQ-030 Shared package level_pkg SHALL hold the state enum (IDLE, PEND) and the constant COUNT_MAX=7.
REQ-031 Sub-module sync_edge (two-flop synchroniser plus rising-edge pulse, clk/rst_n) SHALL be instantiated once per raw input.

Verification (BLINK_DIV=4, COMMIT_TOGGLES=6 unless stated)
REQ-032 Reset, count=0, inc_in rises, first sampled at edge N:
 - busy=1 and blink=1 at N+2.
 - blink toggles at N+6, N+10, N+14, N+18, N+22.
 - At N+26: count=1, blink=0, busy=0.
REQ-033 count=3 in IDLE, single dec_in edge -> count=2 two edges after sampling; dec at count=0 -> count stays 0.
REQ-034 Increment from 0 to 7 via seven commits, then another inc_in edge -> busy stays 0, blink stays 0, count stays 7.
REQ-035 PEND at count=4, dec_in edge -> blink=0, busy=0, count=4 on the acting edge; then a fresh inc_in edge re-enters PEND.
REQ-036 IDLE at count=2, inc_in and dec_in rise on the same cycle -> count=1, busy stays 0.
REQ-037 rst_n pulsed low mid-PEND at count=5 -> all outputs are 0 asynchronously, and count=0 after release.

Source files
------------

// File: rtl/level_pkg.sv
// ---------------------------------------------------------------------------
// level_pkg
// Shared definitions for the level/blink controller slice.
//   state_t   : controller state (IDLE = nothing pending, PEND = increment
//               previewed and waiting for commit)
//   COUNT_MAX : highest committed level
//   LEVEL_W   : width of the committed level
// ---------------------------------------------------------------------------
package level_pkg;

   localparam int LEVEL_W = 3;

   localparam logic [LEVEL_W-1:0] COUNT_MAX = 3'd7;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   // True when the level can still take another increment.
   function automatic logic can_increment(input logic [LEVEL_W-1:0] level);
      return (level != COUNT_MAX);
   endfunction

   // True when the level can still take another decrement.
   function automatic logic can_decrement(input logic [LEVEL_W-1:0] level);
      return (level != '0);
   endfunction

endpackage

// File: rtl/level_blink_ctrl_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Brings one asynchronous request line into the clk domain and turns each
// rising edge of it into a single-cycle pulse.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset, clears every flop
//   async_in : raw request, asynchronous to clk
//   pulse    : one-cycle high for each rising edge of async_in
//
// An input first sampled high at edge N reaches sync_q at edge N+1 while
// prev_q is still low, so pulse is high during the cycle ending at edge N+2.
// ---------------------------------------------------------------------------
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Two-flop synchroniser followed by a delay flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Because prev_q resets low, a line already high at reset release still
   // yields exactly one pulse.
   assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/level_blink_ctrl.sv
// ---------------------------------------------------------------------------
// level_blink_ctrl
// Keeps a committed level 0..7 for a bar display. A decrement request acts
// at once. An increment request first previews the next level by blinking,
// and commits only after COMMIT_TOGGLES prescaler terminal events. A
// decrement during the preview cancels it.
//
// Parameters
//   BLINK_DIV      : blink half-period in clk cycles (>= 2)
//   COMMIT_TOGGLES : terminal events from preview start to commit (>= 1)
// Ports
//   clk    : system clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   inc_in : raw increment request, asynchronous to clk
//   dec_in : raw decrement request, asynchronous to clk
//   count  : committed level, registered
//   blink  : registered preview flag (display shows count+1 bars when 1)
//   busy   : high while an increment is pending
// ---------------------------------------------------------------------------
module level_blink_ctrl #(
   parameter int BLINK_DIV      = 25000000,
   parameter int COMMIT_TOGGLES = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc_in,
   input  logic       dec_in,
   output logic [2:0] count,
   output logic       blink,
   output logic       busy
);

   import level_pkg::*;

   localparam int PRESC_W = $clog2(BLINK_DIV);
   localparam int TOG_W   = $clog2(COMMIT_TOGGLES + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BLINK_DIV - 1);
   localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(COMMIT_TOGGLES - 1);

   logic inc_p;
   logic dec_p;

   state_t             state;
   logic [PRESC_W-1:0] presc;
   logic [TOG_W-1:0]   tog_cnt;
   logic               presc_term;

   sync_edge u_sync_inc (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (inc_in),
      .pulse    (inc_p)
   );

   sync_edge u_sync_dec (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (dec_in),
      .pulse    (dec_p)
   );

   assign presc_term = (presc == PRESC_LAST);

   // Level / preview state machine. A decrement always takes priority over
   // an increment, both in IDLE (inc discarded) and in PEND (cancel, even on
   // a terminal-event cycle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         blink   <= 1'b0;
         presc   <= '0;
         tog_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               presc   <= '0;
               tog_cnt <= '0;
               blink   <= 1'b0;
               if (dec_p) begin
                  if (can_decrement(count)) begin
                     count <= count - 3'd1;
                  end
               end else if (inc_p && can_increment(count)) begin
                  state <= PEND;
                  blink <= 1'b1;
               end
            end

            PEND: begin
               if (dec_p) begin
                  state   <= IDLE;
                  blink   <= 1'b0;
                  presc   <= '0;
                  tog_cnt <= '0;
               end else if (presc_term) begin
                  presc <= '0;
                  // tog_cnt holds the number of terminal events already
                  // seen, so reaching TOG_LAST here means this is the last.
                  if (tog_cnt == TOG_LAST) begin
                     state   <= IDLE;
                     count   <= count + 3'd1;
                     blink   <= 1'b0;
                     tog_cnt <= '0;
                  end else begin
                     blink   <= ~blink;
                     tog_cnt <= tog_cnt + TOG_W'(1);
                  end
               end else begin
                  presc <= presc + PRESC_W'(1);
               end
            end

            default: begin
               state   <= IDLE;
               blink   <= 1'b0;
               presc   <= '0;
               tog_cnt <= '0;
            end
         endcase
      end
   end

   assign busy = (state == PEND);

endmodule

// File: tb/tb_level_blink_ctrl.sv
// ---------------------------------------------------------------------------
// tb_level_blink_ctrl
// Scoreboard bench for level_blink_ctrl with BLINK_DIV=4, COMMIT_TOGGLES=6.
// Expected {count, blink, busy} values are queued against absolute clock
// edge numbers when a request is driven; a monitor compares them on the
// falling edge after the corresponding rising edge.
// ---------------------------------------------------------------------------
module tb_level_blink_ctrl;

   localparam int BLINK_DIV      = 4;
   localparam int COMMIT_TOGGLES = 6;
   localparam int COMMIT_EDGE    = 2 + BLINK_DIV * COMMIT_TOGGLES;

   logic       clk;
   logic       rst_n;
   logic       inc_in;
   logic       dec_in;
   logic [2:0] count;
   logic       blink;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int edgeCnt  = 0;
   int expCount = 0;

   int          cycQ[$];
   logic [31:0] expQ[$];
   string       tagQ[$];

   level_blink_ctrl #(
      .BLINK_DIV      (BLINK_DIV),
      .COMMIT_TOGGLES (COMMIT_TOGGLES)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_in (inc_in),
      .dec_in (dec_in),
      .count  (count),
      .blink  (blink),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt++;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at edge %0d: actual=0x%0h expected=0x%0h",
                  tag, edgeCnt, actual, expected);
      end
   endtask

   function automatic logic [31:0] pack(input int c, input logic bl,
                                        input logic bu);
      logic [2:0] c3;
      c3 = 3'(c);
      return {27'd0, c3, bl, bu};
   endfunction

   task automatic pushExp(input int cyc, input int c, input logic bl,
                          input logic bu, input string tag);
      cycQ.push_back(cyc);
      expQ.push_back(pack(c, bl, bu));
      tagQ.push_back(tag);
   endtask

   // Compare every queued expectation whose edge has been reached.
   always @(negedge clk) begin
      while (cycQ.size() > 0 && cycQ[0] <= edgeCnt) begin
         checkOutput(tagQ[0], pack(int'(count), blink, busy), expQ[0]);
         void'(cycQ.pop_front());
         void'(expQ.pop_front());
         void'(tagQ.pop_front());
      end
   end

   // Drive request lines on a falling edge; n is the rising edge that
   // first samples them.
   task automatic applyStimulus(input logic inc, input logic dec,
                                output int n);
      @(negedge clk);
      inc_in = inc;
      dec_in = dec;
      n = edgeCnt + 1;
   endtask

   task automatic holdAndRelease(input int cycles);
      repeat (cycles) @(negedge clk);
      inc_in = 1'b0;
      dec_in = 1'b0;
   endtask

   task automatic waitEdge(input int target);
      int budget;
      budget = 0;
      while (edgeCnt < target && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
   endtask

   task automatic drain(input int target);
      int budget;
      budget = 0;
      while ((edgeCnt < target || cycQ.size() > 0) && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("drain_pending", 32'(cycQ.size()), 32'd0);
   endtask

   task automatic doCommit(input bit full);
      int n;
      applyStimulus(1'b1, 1'b0, n);
      pushExp(n + 1, expCount, 1'b0, 1'b0, "inc_before_act");
      pushExp(n + 2, expCount, 1'b1, 1'b1, "inc_enter_pend");
      if (full) begin
         for (int k = 1; k < COMMIT_TOGGLES; k++) begin
            pushExp(n + 1 + BLINK_DIV * k, expCount, (k % 2) == 1, 1'b1,
                    "blink_before_toggle");
            pushExp(n + 2 + BLINK_DIV * k, expCount, (k % 2) == 0, 1'b1,
                    "blink_toggle");
         end
      end
      pushExp(n + COMMIT_EDGE - 1, expCount, 1'b0, 1'b1, "before_commit");
      expCount++;
      pushExp(n + COMMIT_EDGE, expCount, 1'b0, 1'b0, "commit");
      holdAndRelease(3);
      drain(n + COMMIT_EDGE + 1);
   endtask

   task automatic doDec();
      int n;
      applyStimulus(1'b0, 1'b1, n);
      pushExp(n + 1, expCount, 1'b0, 1'b0, "dec_before_act");
      if (expCount > 0) expCount--;
      pushExp(n + 2, expCount, 1'b0, 1'b0, "dec_act");
      pushExp(n + 5, expCount, 1'b0, 1'b0, "dec_settled");
      holdAndRelease(3);
      drain(n + 6);
   endtask

   task automatic incAtMax();
      int n;
      applyStimulus(1'b1, 1'b0, n);
      pushExp(n + 2, 7, 1'b0, 1'b0, "inc_at_max_act");
      pushExp(n + 6, 7, 1'b0, 1'b0, "inc_at_max_later");
      holdAndRelease(3);
      drain(n + 7);
   endtask

   task automatic bothSameCycle();
      int n;
      applyStimulus(1'b1, 1'b1, n);
      expCount--;
      pushExp(n + 2, expCount, 1'b0, 1'b0, "both_dec_wins");
      pushExp(n + 6, expCount, 1'b0, 1'b0, "both_no_pend");
      holdAndRelease(3);
      drain(n + 7);
   endtask

   // Decrement lands exactly on the second terminal event of the preview.
   task automatic cancelInPend();
      int n;
      int m;
      applyStimulus(1'b1, 1'b0, n);
      pushExp(n + 2, expCount, 1'b1, 1'b1, "cancel_pend");
      holdAndRelease(3);
      waitEdge(n + 6);
      applyStimulus(1'b0, 1'b1, m);
      pushExp(m + 1, expCount, 1'b0, 1'b1, "cancel_before_act");
      pushExp(m + 2, expCount, 1'b0, 1'b0, "cancel_act");
      pushExp(m + 6, expCount, 1'b0, 1'b0, "cancel_stays_idle");
      holdAndRelease(3);
      drain(m + 7);
   endtask

   task automatic resetMidPend();
      int n;
      int r;
      applyStimulus(1'b1, 1'b0, n);
      pushExp(n + 2, expCount, 1'b1, 1'b1, "rst_pend_entry");
      holdAndRelease(3);
      drain(n + 7);
      #2;
      rst_n  = 1'b0;
      inc_in = 1'b1;
      #1;
      checkOutput("rst_async_count", 32'(count), 32'd0);
      checkOutput("rst_async_blink", 32'(blink), 32'd0);
      checkOutput("rst_async_busy",  32'(busy),  32'd0);
      repeat (2) @(negedge clk);
      checkOutput("rst_held_out", pack(int'(count), blink, busy),
                  pack(0, 1'b0, 1'b0));
      rst_n = 1'b1;
      r = edgeCnt + 1;
      expCount = 0;
      pushExp(r + 1, 0, 1'b0, 1'b0, "rel_before_pulse");
      pushExp(r + 2, 0, 1'b1, 1'b1, "rel_held_pulse");
      pushExp(r + COMMIT_EDGE, 1, 1'b0, 1'b0, "rel_commit");
      pushExp(r + COMMIT_EDGE + 4, 1, 1'b0, 1'b0, "rel_single_pulse");
      waitEdge(r + COMMIT_EDGE + 2);
      inc_in = 1'b0;
      drain(r + COMMIT_EDGE + 5);
      expCount = 1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n  = 1'b0;
      inc_in = 1'b0;
      dec_in = 1'b0;
      #12;
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_blink", 32'(blink), 32'd0);
      checkOutput("reset_busy",  32'(busy),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] first increment with full blink trace");
      doCommit(1'b1);
      doCommit(1'b0);
      doCommit(1'b0);

      $display("[TB] decrements down to and below zero");
      repeat (4) doDec();

      $display("[TB] seven commits to the top level");
      repeat (7) doCommit(1'b0);
      incAtMax();

      $display("[TB] simultaneous requests at level 2");
      repeat (5) doDec();
      bothSameCycle();

      $display("[TB] cancel during preview at level 4");
      repeat (3) doCommit(1'b0);
      cancelInPend();
      doCommit(1'b0);

      $display("[TB] reset during preview at level 5");
      resetMidPend();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
